// File: rtl/screen_fade_if.sv
// Screen-change request handshake between a requester (master) and the
// fade sequencer (slave).
//   req_valid  : request valid (master -> slave)
//   req_screen : requested screen index 0..3 (master -> slave)
//   req_ready  : sequencer idle and able to accept (slave -> master)
//   done       : one-cycle completion pulse (slave -> master)
//   busy       : transition in progress (slave -> master)
interface screen_fade_if;
  logic       req_valid;
  logic [1:0] req_screen;
  logic       req_ready;
  logic       done;
  logic       busy;

  modport master (output req_valid, req_screen, input req_ready, done, busy);
  modport slave  (input req_valid, req_screen, output req_ready, done, busy);
endinterface

// File: rtl/screen_fade_sequencer.sv
// Screen fade sequencer: on a screen-change request, fades the global RGB
// level 15 -> 0 on frame ticks, switches the chain mux select while black,
// then fades back 0 -> 15. Every level/select change happens on a v_sync
// active edge so no frame shows a mid-frame change.
//   clk_25      : pixel clock
//   reset       : synchronous, active-high
//   v_sync      : raw vertical sync from the VGA controller
//   req_if      : request handshake (req_valid/req_screen/req_ready/done/busy)
//   screen_sel  : current screen index, drives the chain mux
//   *_level     : registered per-colour levels, masked per screen
module screen_fade_sequencer #(
  parameter int          FRAMES_PER_STEP = 2,
  parameter int          INIT_SCREEN     = 0,
  parameter int          VSYNC_ACTIVE    = 0,
  parameter logic [11:0] SCREEN_MASK     = 12'hFFF
) (
  input  logic         clk_25,
  input  logic         reset,
  input  logic         v_sync,
  screen_fade_if.slave req_if,
  output logic [1:0]   screen_sel,
  output logic [3:0]   Red_level,
  output logic [3:0]   Green_level,
  output logic [3:0]   Blue_level
);
  typedef enum logic [1:0] {IDLE, FADE_OUT, SWITCH, FADE_IN} state_t;

  localparam logic       VS_ACT    = (VSYNC_ACTIVE != 0);
  localparam logic [1:0] INIT_SEL  = 2'(INIT_SCREEN);
  localparam logic [3:0] STEP_LAST = 4'(FRAMES_PER_STEP - 1);
  localparam logic [2:0] INIT_MASK = SCREEN_MASK[3*INIT_SCREEN +: 3];

  state_t     state;
  logic [3:0] level;
  logic [3:0] frame_cnt;
  logic [1:0] target;
  logic       vs_q;
  logic       done_q;
  logic [2:0][3:0] col_q; // [2]=R [1]=G [0]=B

  // Active edge of v_sync: one cycle per frame.
  logic tick, step_now;
  assign tick     = (vs_q != VS_ACT) && (v_sync == VS_ACT);
  assign step_now = tick && (frame_cnt == STEP_LAST);

  assign req_if.busy      = (state != IDLE);
  assign req_if.req_ready = (state == IDLE);
  assign req_if.done      = done_q;

  always_ff @(posedge clk_25) begin
    if (reset) begin
      state      <= IDLE;
      level      <= 4'd15;
      screen_sel <= INIT_SEL;
      target     <= INIT_SEL;
      frame_cnt  <= 4'd0;
      vs_q       <= ~VS_ACT;
      done_q     <= 1'b0;
    end else begin
      vs_q   <= v_sync;
      done_q <= 1'b0;
      case (state)
        IDLE: if (req_if.req_valid) begin
          // Same screen: nothing to fade, just acknowledge.
          if (req_if.req_screen == screen_sel) done_q <= 1'b1;
          else begin
            target    <= req_if.req_screen;
            frame_cnt <= 4'd0;
            state     <= FADE_OUT;
          end
        end
        FADE_OUT: if (tick) begin
          if (step_now) begin
            frame_cnt <= 4'd0;
            if (level != 4'd0) level <= level - 4'd1;
            if (level <= 4'd1) state <= SWITCH;
          end else frame_cnt <= frame_cnt + 4'd1;
        end
        // Held black for a full frame before the select changes.
        SWITCH: if (tick) begin
          screen_sel <= target;
          frame_cnt  <= 4'd0;
          state      <= FADE_IN;
        end
        FADE_IN: if (tick) begin
          if (step_now) begin
            frame_cnt <= 4'd0;
            if (level != 4'd15) level <= level + 4'd1;
            if (level >= 4'd14) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end else frame_cnt <= frame_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Colour outputs lag level/screen_sel by one cycle.
  logic [2:0] cur_mask;
  assign cur_mask = SCREEN_MASK[3*int'(screen_sel) +: 3];

  always_ff @(posedge clk_25) begin
    for (int c = 0; c < 3; c++) begin
      if (reset) col_q[c] <= INIT_MASK[c] ? 4'd15 : 4'd0;
      else       col_q[c] <= cur_mask[c] ? level : 4'd0;
    end
  end

  assign Red_level   = col_q[2];
  assign Green_level = col_q[1];
  assign Blue_level  = col_q[0];
endmodule
